// File: rtl/leaf_pkt_pkg.sv
// leaf_pkt_pkg: default BFT packet field widths, field offsets, credit ceiling and packet assembly
package leaf_pkt_pkg;
  localparam int PAYLOAD_W = 32;
  localparam int LEAF_W = 5;
  localparam int PORT_W = 4;
  localparam int ADDR_W = 7;
  localparam int PACKET_W = 1 + LEAF_W + PORT_W + ADDR_W + PAYLOAD_W;
  localparam int ADDR_LSB = PAYLOAD_W;
  localparam int PORT_LSB = ADDR_LSB + ADDR_W;
  localparam int LEAF_LSB = PORT_LSB + PORT_W;
  localparam int VALID_BIT = LEAF_LSB + LEAF_W;
  localparam int CREDIT_MAX = 2 ** ADDR_W;
  localparam int FREESPACE_DEF = 64;
  function automatic logic [PACKET_W-1:0] make_pkt(input logic [LEAF_W-1:0] leaf,
                                                   input logic [PORT_W-1:0] port,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [PAYLOAD_W-1:0] payload);
    return {1'b1, leaf, port, addr, payload};
  endfunction
endpackage

// File: rtl/leaf_out_if.sv
// leaf_out_if: user output streams (din/vld/ack) plus BFT side (dout/bft_ready/resend); slave = arbiter
interface leaf_out_if import leaf_pkt_pkg::*; #(
  parameter int N = 3,
  parameter int PAYLOAD_BITS = PAYLOAD_W,
  parameter int PACKET_BITS = PACKET_W
) ();
  logic [N*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [N-1:0] vld_user2interface;
  logic [N-1:0] ack_interface2user;
  logic bft_ready;
  logic resend;
  logic [PACKET_BITS-1:0] dout_leaf_interface2bft;
  modport slave(input din_leaf_user2interface, vld_user2interface, bft_ready, resend,
                output ack_interface2user, dout_leaf_interface2bft);
  modport master(output din_leaf_user2interface, vld_user2interface, bft_ready, resend,
                 input ack_interface2user, dout_leaf_interface2bft);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr in, one-hot grant and valid out
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++)
      if (!valid && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: merges NUM_OUT_PORTS user streams into one BFT packet stream; ports: clk, reset, cfg_dest_leaf/port, credit_vld/port, bus (leaf_out_if.slave); LEAF_OUT_STATS_EN adds sent_count/stall_cycles
module leaf_out_arbiter import leaf_pkt_pkg::*; #(
  parameter int NUM_OUT_PORTS = 3,
  parameter int PAYLOAD_BITS = PAYLOAD_W,
  parameter int NUM_LEAF_BITS = LEAF_W,
  parameter int NUM_PORT_BITS = PORT_W,
  parameter int NUM_ADDR_BITS = ADDR_W,
  parameter int FREESPACE_UPDATE_SIZE = FREESPACE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic credit_vld,
  input  logic [NUM_PORT_BITS-1:0] credit_port,
`ifdef LEAF_OUT_STATS_EN
  output logic [NUM_OUT_PORTS*16-1:0] sent_count,
  output logic [15:0] stall_cycles,
`endif
  leaf_out_if.slave bus
);
  localparam int N = NUM_OUT_PORTS;
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam int CW = NUM_ADDR_BITS + 1;
  localparam int CMAX = 2 ** NUM_ADDR_BITS;
  localparam int PACKET_BITS = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
  logic [CW-1:0] credit [N];
  logic [CW-1:0] credit_nxt [N];
  logic [NUM_ADDR_BITS-1:0] addr [N];
  logic [PW-1:0] rr_ptr, gidx;
  logic [PACKET_BITS-1:0] pkt_q;
  logic pkt_vld_q, load_en, gv;
  logic [N-1:0] eligible, gnt, ack;
  always_comb
    for (int i = 0; i < N; i++) eligible[i] = bus.vld_user2interface[i] & (credit[i] != '0);
  assign load_en = !reset && !bus.resend && (!pkt_vld_q || bus.bft_ready);
  rr_arbiter #(.N(N)) u_rr (.req(eligible), .ptr(rr_ptr), .grant(gnt), .valid(gv));
  assign ack = load_en ? gnt : '0;
  assign bus.ack_interface2user = ack;
  assign bus.dout_leaf_interface2bft = (bus.resend || !pkt_vld_q) ? '0 : pkt_q;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) if (gnt[i]) gidx = PW'(i);
  end
  // A same-cycle grant and return nets out before saturating at the ceiling.
  always_comb begin
    int c;
    for (int i = 0; i < N; i++) begin
      c = int'(credit[i]) - int'(ack[i]) +
          ((credit_vld && int'(credit_port) == i) ? FREESPACE_UPDATE_SIZE : 0);
      credit_nxt[i] = c > CMAX ? CW'(CMAX) : CW'(c);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q <= '0;
      pkt_vld_q <= 1'b0;
      rr_ptr <= '0;
      for (int i = 0; i < N; i++) begin
        credit[i] <= CW'(CMAX);
        addr[i] <= '0;
      end
    end else begin
      if (load_en && gv) begin
        pkt_q <= {1'b1, cfg_dest_leaf[int'(gidx)*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                  cfg_dest_port[int'(gidx)*NUM_PORT_BITS +: NUM_PORT_BITS], addr[gidx],
                  bus.din_leaf_user2interface[int'(gidx)*PAYLOAD_BITS +: PAYLOAD_BITS]};
        pkt_vld_q <= 1'b1;
        rr_ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
      end else if (load_en && pkt_vld_q && bus.bft_ready) pkt_vld_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        credit[i] <= credit_nxt[i];
        if (ack[i]) addr[i] <= addr[i] + 1'b1;
      end
    end
  end
`ifdef LEAF_OUT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_count <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < N; i++) if (ack[i]) sent_count[i*16 +: 16] <= sent_count[i*16 +: 16] + 16'd1;
      if (pkt_vld_q && !bus.bft_ready && !bus.resend && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif
endmodule
